// File: rtl/ifetch_pc_if.sv
// ----------------------------------------------------------------------------
// ifetch_pc_if : fetch-side bus (IM address/data and the decode valid/ready pair)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ifetch_pc_if;
  logic [11:0] pc;
  logic [31:0] im_now;
  logic [31:0] ir;
  logic [11:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;

  modport master (
    output pc, ir, ir_pc, ir_valid,
    input  im_now, ir_ready
  );

  modport slave (
    input  pc, ir, ir_pc, ir_valid,
    output im_now, ir_ready
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_pc.sv
// ----------------------------------------------------------------------------
// ifetch_pc : PC owner and instruction register with stall, redirect, halt.
// Optional macro SYSCALL_HALT_EN: a captured syscall (32'h0000000C) halts fetch.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ifetch_pc #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  ifetch_pc_if.master bus,
  input  logic        redirect,
  input  logic [11:0] redirect_addr,
  output logic        halt,
  input  logic        resume
);

  localparam logic [11:0] C_RESET_PC = {RESET_PC[11:2], 2'b00};

  logic [11:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [11:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        w_run;
  logic        w_cap;

`ifdef SYSCALL_HALT_EN
  localparam logic [31:0] C_SYSCALL = 32'h0000000C;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  assign w_run = (state_q == S_RUN);
  assign halt  = (state_q == S_HALT);

  // Redirect beats resume; a syscall only halts if it was actually captured.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = S_RUN;
    end else if (state_q == S_HALT) begin
      if (resume) state_d = S_RUN;
    end else if (w_cap && (bus.im_now == C_SYSCALL)) begin
      state_d = S_HALT;
    end
  end
`else
  logic unused_resume;
  assign unused_resume = resume;
  assign w_run = 1'b1;
  assign halt  = 1'b0;
`endif

  assign w_cap = w_run && !redirect && (!ir_valid_q || bus.ir_ready);

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (redirect) begin
      pc_d       = {redirect_addr[11:2], 2'b00};
      ir_valid_d = 1'b0;
    end else if (w_cap) begin
      ir_d       = bus.im_now;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + 12'd4;
    end else if (ir_valid_q && bus.ir_ready) begin
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= C_RESET_PC;
      ir_q       <= 32'h0;
      ir_pc_q    <= 12'h0;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  logic [1:0] unused_addr_lsbs;
  assign unused_addr_lsbs = redirect_addr[1:0];

  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;

endmodule

`default_nettype wire

// File: doc/ifetch_pc.md
# ifetch_pc

Instruction-fetch stage sitting directly upstream of the instruction memory (IM). It owns the program counter and drives the IM's 12-bit byte address. It captures the combinational 32-bit instruction word the IM returns into an instruction register. That register is handed to decode over a valid/ready handshake, with support for stall, redirect (branch/jump) and halt/resume.

## Interface
Parameters:
- RESET_PC, 12'h000, byte address loaded into pc on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc  out  12  byte address to IM addr input; always word-aligned.
- im_now  in  32  instruction word from IM; combinational function of pc, valid same cycle.
- ir  out  32  captured instruction.
- ir_pc  out  12  address ir was fetched from.
- ir_valid  out  1  ir holds an instruction not yet consumed.
- ir_ready  in  1  decode accepts ir this cycle when ir_valid=1.
- redirect  in  1  one-cycle request to restart fetch at redirect_addr.
- redirect_addr  in  12  target byte address; bits [1:0] ignored and forced to 0.
- halt  out  1  fetch halted (only with SYSCALL_HALT_EN).
- resume  in  1  leave halt state.

## Operation
- States: RUN, HALT. Reset → RUN.
- Capture condition (RUN only): cap = !redirect && (!ir_valid || ir_ready).
- On cap: ir←im_now, ir_pc←pc, ir_valid←1, pc←pc+4.
- Handshake accepted (ir_valid && ir_ready) without cap: ir_valid←0.
- Stall (ir_valid=1, ir_ready=0, no redirect): pc, ir, ir_pc, ir_valid hold.
- Redirect (any state, highest priority): pc←{redirect_addr[11:2],2'b00}, ir_valid←0 (flush), state←RUN. An accept coinciding with redirect counts as consumed. ir/ir_pc contents are don't-care while invalid.
- Arithmetic: pc+4 is 12-bit modulo. 12'hFFC wraps to 12'h000, no flag.
- HALT: no captures. pc holds. An existing valid ir still drains via ir_ready. resume → RUN next edge. redirect overrides resume.
- Reset mid-operation: all registers immediately to reset values, regardless of clk.

## Timing
- Reset values: pc=RESET_PC, ir=32'h0, ir_pc=12'h0, ir_valid=0, halt=0, state=RUN.
- First capture at the first rising edge after rst_n deasserts: ir=IM[RESET_PC].
- Steady-state throughput: one instruction per cycle while ir_ready=1.
- Fetch latency: pc→ir_valid is one edge.
- Redirect latency: redirect sampled at edge N. Target presented on pc during cycle N+1. Target in ir with ir_valid=1 after edge N+1.
- halt asserts the edge after the halting instruction is captured. It deasserts the edge resume or redirect is sampled. The first capture after resume occurs one edge later.

## Configuration
- SYSCALL_HALT_EN defined:
  - Capturing im_now==32'h0000000C (syscall) behaves as a normal capture (pc advances past it) and also moves the state to HALT; halt=1 from the next cycle.
  - A syscall captured in the same edge as a redirect is not captured (redirect wins).
- SYSCALL_HALT_EN undefined:
  - HALT state absent; halt tied 0; resume ignored.
  - Syscall is an ordinary instruction.

## Test plan
- Reset/stream: RESET_PC=0, IM words W0..W3 at 0,4,8,C, ir_ready=1. Edges 1–4 give ir=W0..W3, ir_pc=0,4,8,C. pc ends at 12'h010.
- Stall: ir_ready=0 for 3 cycles after capturing addr 8. ir stays W2, ir_pc=8, pc stays C. With ir_ready=1 restored, W3 appears next edge.
- Redirect: while ir_pc=4, pulse redirect with redirect_addr=12'h083. Next edge ir_valid=0, pc=12'h080. Following edge ir=IM[0x80], ir_pc=12'h080.
- Wrap: redirect to 12'hFFC, ir_ready=1. Captures ir_pc=FFC, then 000, then 004.
- Async reset: assert rst_n=0 mid-cycle during a stall. Outputs go to reset values before the next clk edge. Fetch restarts at RESET_PC.
- Halt (SYSCALL_HALT_EN): syscall at 0x10. After its capture, halt=1 and pc=14. With ir_ready=1, ir_valid drops next edge and no further captures for 5 cycles. A resume pulse clears halt, and the next edge captures ir_pc=14. Without the macro, halt stays 0 and 0x14 follows immediately.
